data_pipe_reg: RTL and testbench

- Parametrised, multi-stage valid/ready register slice for the morphological-operation pixel pipeline.
- Successor to the single valid-qualified data register: adds configurable depth and downstream backpressure.
- Each stage is a skid buffer, so throughput stays at one beat per clock with fully registered ready paths.
- Sits between window/line-buffer logic and the erode/dilate kernels. It breaks timing paths and absorbs stalls without dropping pixels.

---
 rtl/data_pipe_reg.sv | 159 +++++++++++++++
 tb/tb_data_pipe_reg.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pipe_reg.sv
// data_pipe_reg: cascaded valid/ready skid-buffer register slice.
// Each of the DEPTH stages holds up to two beats (main + skid), so the pipe
// stores up to 2*DEPTH beats. Beats move at one per clock, and every ready is
// taken straight from a flop.
// Optional feature: define DATA_PIPE_OCC_EN to add the o_occupancy port and
// its beat counter.
module data_pipe_reg #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready
`ifdef DATA_PIPE_OCC_EN
  ,
  output logic [$clog2(2*DEPTH+1)-1:0] o_occupancy
`endif
);

  // Bit 0 = main valid, bit 1 = skid valid; skid is never valid without main.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } stage_state_t;

  stage_state_t          state_q [DEPTH];
  stage_state_t          state_d [DEPTH];
  logic [DATA_WIDTH-1:0] main_q  [DEPTH];
  logic [DATA_WIDTH-1:0] main_d  [DEPTH];
  logic [DATA_WIDTH-1:0] skid_q  [DEPTH];
  logic [DATA_WIDTH-1:0] skid_d  [DEPTH];
  logic [DATA_WIDTH-1:0] in_data [DEPTH];

  logic [DEPTH-1:0] main_valid;
  logic [DEPTH-1:0] skid_valid;
  logic [DEPTH-1:0] in_valid;
  logic [DEPTH-1:0] out_ready;

  // Decode per-stage occupancy flags from the registered state.
  always_comb begin
    main_valid = '0;
    skid_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      main_valid[k] = (state_q[k] != S_EMPTY);
      skid_valid[k] = (state_q[k] == S_TWO);
    end
  end

  // Chain the stages: stage k's output handshake is stage k+1's input handshake.
  always_comb begin
    in_valid  = '0;
    out_ready = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      in_data[k] = '0;
    end
    in_valid[0] = i_data_valid;
    in_data[0]  = i_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      in_valid[k] = main_valid[k-1];
      in_data[k]  = main_q[k-1];
    end
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      out_ready[k] = ~skid_valid[k+1];
    end
    out_ready[DEPTH-1] = i_data_ready;
  end

  // Per-stage next state and data; a register loads only on its own accept.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      state_d[k] = state_q[k];
      main_d[k]  = main_q[k];
      skid_d[k]  = skid_q[k];
      case (state_q[k])
        S_EMPTY: begin
          if (in_valid[k]) begin
            main_d[k]  = in_data[k];
            state_d[k] = S_ONE;
          end
        end
        S_ONE: begin
          if (in_valid[k] && out_ready[k]) begin
            main_d[k] = in_data[k];
          end else if (in_valid[k]) begin
            skid_d[k]  = in_data[k];
            state_d[k] = S_TWO;
          end else if (out_ready[k]) begin
            state_d[k] = S_EMPTY;
          end
        end
        S_TWO: begin
          // Input is not ready here, so only the drain case moves anything.
          if (out_ready[k]) begin
            main_d[k]  = skid_q[k];
            state_d[k] = S_ONE;
          end
        end
        default: state_d[k] = S_EMPTY;
      endcase
    end
  end

  // Stage registers with synchronous reset of flags and payload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        state_q[k] <= S_EMPTY;
        main_q[k]  <= '0;
        skid_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        state_q[k] <= state_d[k];
        main_q[k]  <= main_d[k];
        skid_q[k]  <= skid_d[k];
      end
    end
  end

  assign o_data       = main_q[DEPTH-1];
  assign o_data_valid = main_valid[DEPTH-1];
  assign o_data_ready = ~skid_valid[0];

`ifdef DATA_PIPE_OCC_EN
  localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

  logic             up_xfer;
  logic             dn_xfer;
  logic [OCC_W-1:0] occ_q;

  // Handshakes at the pipe boundary drive the beat counter.
  always_comb begin
    up_xfer = i_data_valid & o_data_ready;
    dn_xfer = o_data_valid & i_data_ready;
  end

  // Beat counter: +1 on entry, -1 on exit, unchanged when both or neither.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occ_q <= '0;
    end else begin
      case ({up_xfer, dn_xfer})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign o_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_data_pipe_reg.sv
// tb_data_pipe_reg: scoreboard bench for data_pipe_reg.
// Instance a: DATA_WIDTH=8, DEPTH=2. Instance b: DATA_WIDTH=1, DEPTH=1.
// Define DATA_PIPE_OCC_EN to also check o_occupancy.
module tb_data_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- instance a ----------------
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] a_odata;
  logic       a_ovalid;
  logic       a_iready = 1'b1;
`ifdef DATA_PIPE_OCC_EN
  logic [2:0] a_occ;
`endif

  data_pipe_reg #(.DATA_WIDTH(8), .DEPTH(2)) u_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (a_data),
    .i_data_valid (a_valid),
    .o_data_ready (a_ready),
    .o_data       (a_odata),
    .o_data_valid (a_ovalid),
    .i_data_ready (a_iready)
`ifdef DATA_PIPE_OCC_EN
    ,
    .o_occupancy  (a_occ)
`endif
  );

  // ---------------- instance b ----------------
  logic       b_data = 1'b0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       b_odata;
  logic       b_ovalid;
  logic       b_iready = 1'b1;
`ifdef DATA_PIPE_OCC_EN
  logic [1:0] b_occ;
`endif

  data_pipe_reg #(.DATA_WIDTH(1), .DEPTH(1)) u_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (b_data),
    .i_data_valid (b_valid),
    .o_data_ready (b_ready),
    .o_data       (b_odata),
    .o_data_valid (b_ovalid),
    .i_data_ready (b_iready)
`ifdef DATA_PIPE_OCC_EN
    ,
    .o_occupancy  (b_occ)
`endif
  );

  // ---------------- scoreboards ----------------
  logic [7:0] a_q[$];
  logic       b_q[$];
  int   a_exp_occ = 0, b_exp_occ = 0;
  bit   a_prev_stall = 0, b_prev_stall = 0;
  logic [7:0] a_prev_data = '0;
  logic       b_prev_data = 1'b0;
  bit   a_arm = 0, b_arm = 0;
  int   a_rise_cyc = 0, b_rise_cyc = 0;
  int   a_acc_cyc = 0, b_acc_cyc = 0;
  int   a_last_out_cyc = 0;
  bit   a_rand = 0, b_tog = 0;

  // Monitor a: pops on every downstream transfer, checks stall hold and occupancy.
  always @(negedge clk) begin
    if (rst) begin
      a_q.delete();
      a_exp_occ    = 0;
      a_prev_stall = 0;
    end else begin
      if (a_prev_stall) begin
        check("a_hold_valid", a_ovalid, 1);
        check("a_hold_data", a_odata, a_prev_data);
      end
`ifdef DATA_PIPE_OCC_EN
      check("a_occ", a_occ, a_exp_occ);
`endif
      if (a_arm && a_ovalid) begin
        a_rise_cyc = cyc;
        a_arm      = 0;
      end
      if (a_ovalid && a_iready) begin
        if (a_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_extra_beat: got 0x%0h expected no beat (cycle %0d)", a_odata, cyc);
        end else begin
          check("a_data", a_odata, a_q.pop_front());
        end
        a_last_out_cyc = cyc;
      end
      a_exp_occ    = a_exp_occ + int'(a_valid && a_ready) - int'(a_ovalid && a_iready);
      a_prev_stall = a_ovalid && !a_iready;
      a_prev_data  = a_odata;
    end
  end

  // Monitor b: same checks for the single-stage instance.
  always @(negedge clk) begin
    if (rst) begin
      b_q.delete();
      b_exp_occ    = 0;
      b_prev_stall = 0;
    end else begin
      if (b_prev_stall) begin
        check("b_hold_valid", b_ovalid, 1);
        check("b_hold_data", b_odata, b_prev_data);
      end
`ifdef DATA_PIPE_OCC_EN
      check("b_occ", b_occ, b_exp_occ);
`endif
      if (b_arm && b_ovalid) begin
        b_rise_cyc = cyc;
        b_arm      = 0;
      end
      if (b_ovalid && b_iready) begin
        if (b_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_extra_beat: got %0d expected no beat (cycle %0d)", b_odata, cyc);
        end else begin
          check("b_data", b_odata, b_q.pop_front());
        end
      end
      b_exp_occ    = b_exp_occ + int'(b_valid && b_ready) - int'(b_ovalid && b_iready);
      b_prev_stall = b_ovalid && !b_iready;
      b_prev_data  = b_odata;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_a(input logic [7:0] d, output int waits);
    bit done = 0;
    waits   = 0;
    a_data  = d;
    a_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (a_ready) begin
        a_q.push_back(d);
        a_acc_cyc = cyc;
        done      = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
      if (a_rand) a_iready = 1'($urandom_range(0, 1));
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL a_send_timeout: got no accept expected accept of 0x%0h", d);
    end
  endtask

  task automatic idle_a(input int n);
    a_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (a_rand) a_iready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_empty_a();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (a_q.size() == 0) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL a_drain_timeout: got %0d beats pending expected 0", a_q.size());
    end
  endtask

  task automatic send_b(input logic d);
    bit done = 0;
    b_data  = d;
    b_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b_ready) begin
        b_q.push_back(d);
        b_acc_cyc = cyc;
        done      = 1;
      end
      @(posedge clk);
      #1;
      if (b_tog) b_iready = ~b_iready;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL b_send_timeout: got no accept expected accept of %0d", d);
    end
  endtask

  task automatic wait_empty_b();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b_q.size() == 0) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL b_drain_timeout: got %0d beats pending expected 0", b_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, wsum, c0, cd;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_rst_valid", a_ovalid, 0);
    check("a_rst_data", a_odata, 0);
    check("a_rst_ready", a_ready, 1);
    check("b_rst_valid", b_ovalid, 0);
    check("b_rst_data", b_odata, 0);
    check("b_rst_ready", b_ready, 1);
`ifdef DATA_PIPE_OCC_EN
    check("a_rst_occ", a_occ, 0);
    check("b_rst_occ", b_occ, 0);
`endif
    @(posedge clk);
    #1;

    // Streaming 0x01..0x10 with downstream always ready.
    a_iready = 1'b1;
    a_arm    = 1;
    wsum     = 0;
    c0       = 0;
    for (int i = 1; i <= 16; i++) begin
      send_a(8'(i), w);
      if (i == 1) c0 = a_acc_cyc;
      wsum += w;
    end
    a_valid = 1'b0;
    wait_empty_a();
    check("stream_ready_stalls", wsum, 0);
    check("stream_latency", a_rise_cyc - c0, 2);
    check("stream_last_out", a_last_out_cyc - c0, 17);

    // Fill with downstream stalled: four beats fit, the fifth waits.
    a_iready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(8'hA0 + 8'(i), w);
    a_data  = 8'hA4;
    a_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fill_ready", a_ready, 0);
      check("fill_odata", a_odata, 8'hA0);
      check("fill_ovalid", a_ovalid, 1);
`ifdef DATA_PIPE_OCC_EN
      check("fill_occ", a_occ, 4);
`endif
      @(posedge clk);
      #1;
    end

    // Drain: the freed slot moves back one stage per cycle, so with two
    // stages the input sees ready again after the second drain edge.
    a_iready = 1'b1;
    cd       = cyc;
    send_a(8'hA4, w);
    check("drain_ready_waits", w, 2);
    send_a(8'hA5, w);
    a_valid = 1'b0;
    wait_empty_a();
    check("drain_last_out", a_last_out_cyc - cd, 5);
    @(negedge clk);
    check("drain_idle_valid", a_ovalid, 0);
    check("drain_retain_data", a_odata, 8'hA5);
`ifdef DATA_PIPE_OCC_EN
    check("drain_occ", a_occ, 0);
`endif
    @(posedge clk);
    #1;

    // Random stall: 1000 incrementing beats, random idles and backpressure.
    a_rand = 1;
    for (int i = 0; i < 1000; i++) begin
      send_a(8'(i), w);
      if ($urandom_range(0, 1) == 1) idle_a(1);
    end
    a_rand   = 0;
    a_valid  = 1'b0;
    a_iready = 1'b1;
    wait_empty_a();

    // Reset while three beats are held.
    a_iready = 1'b0;
    for (int i = 0; i < 3; i++) send_a(8'h31 + 8'(i), w);
    a_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", a_ovalid, 0);
    check("mid_rst_data", a_odata, 0);
    check("mid_rst_ready", a_ready, 1);
`ifdef DATA_PIPE_OCC_EN
    check("mid_rst_occ", a_occ, 0);
`endif
    @(posedge clk);
    #1;
    a_iready = 1'b1;
    a_arm    = 1;
    send_a(8'h55, w);
    c0      = a_acc_cyc;
    a_valid = 1'b0;
    wait_empty_a();
    check("post_rst_latency", a_rise_cyc - c0, 2);

    // Single-stage 1-bit pipe: capacity two, latency one.
    b_iready = 1'b0;
    b_arm    = 1;
    send_b(1'b1);
    c0 = b_acc_cyc;
    send_b(1'b0);
    b_valid = 1'b0;
    @(negedge clk);
    check("b_full_ready", b_ready, 0);
    check("b_latency", b_rise_cyc - c0, 1);
    check("b_full_odata", b_odata, 1);
`ifdef DATA_PIPE_OCC_EN
    check("b_full_occ", b_occ, 2);
`endif
    @(posedge clk);
    #1;
    b_tog = 1;
    for (int i = 0; i < 8; i++) send_b(1'((i + 1) % 2));
    b_tog    = 0;
    b_valid  = 1'b0;
    b_iready = 1'b1;
    wait_empty_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
